// File: rtl/ddr_line_arbiter_if.sv
// Requester and MCB command-port signals shared by the DDR line arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface ddr_line_arbiter_if #(
    parameter int ADDR_W = 28
);
    logic [2:0]        req;
    logic [2:0]        we;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] addr2;
    logic [6:0]        len0;
    logic [6:0]        len1;
    logic [6:0]        len2;
    logic [2:0]        done;
    logic [2:0]        gnt;
    logic              cmd_en;
    logic [2:0]        cmd_instr;
    logic [5:0]        cmd_bl;
    logic [ADDR_W+1:0] cmd_byte_addr;
    logic              cmd_full;
    logic              busy;
    logic              err_timeout;
    logic [7:0]        err_count;
    logic [1:0]        state_dbg;

    // Handshake: cmd_en fires only in a CMD cycle where cmd_full is low; grants
    // are released solely by done from the owner or by the watchdog.
    modport slave (
        input  req, we, addr0, addr1, addr2, len0, len1, len2, done, cmd_full,
        output gnt, cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, busy,
               err_timeout, err_count, state_dbg
    );

    modport master (
        output req, we, addr0, addr1, addr2, len0, len1, len2, done, cmd_full,
        input  gnt, cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, busy,
               err_timeout, err_count, state_dbg
    );
endinterface

// File: rtl/ddr_line_arbiter.sv
// Three-requester arbiter for the DDR2 MCB command port: display reads take
// priority up to MAX_DISP in a row, capture and processing share round-robin.
module ddr_line_arbiter #(
    parameter int ADDR_W   = 28,
    parameter int MAX_DISP = 4,
    parameter int TIMEOUT  = 1023
) (
    input logic                 clk,
    input logic                 reset_n,
    ddr_line_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam int DW = $clog2(MAX_DISP + 1);

    state_t            state;
    state_t            next_state;
    logic [DW-1:0]     disp_run;
    logic [1:0]        rr_ptr;
    logic [1:0]        rr_other;
    logic [1:0]        win;
    logic              rr_req;
    logic              pick0;
    logic [9:0]        wd_cnt;
    logic              owner_done;
    logic              wd_expire;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [6:0]        sel_len;
    logic [6:0]        len_m1;
    logic [2:0]        gnt;
    logic [2:0]        cmd_instr;
    logic [5:0]        cmd_bl;
    logic [ADDR_W+1:0] cmd_byte_addr;
    logic              err_timeout;
    logic [7:0]        err_count;

    // Winner selection; display yields only when the others are actually waiting.
    always_comb begin
        rr_other = (rr_ptr == 2'd1) ? 2'd2 : 2'd1;
        rr_req   = (rr_ptr == 2'd2) ? bus.req[2] : bus.req[1];
        pick0    = bus.req[0] && ((disp_run < DW'(MAX_DISP)) || (bus.req[2:1] == 2'b00));
        if (pick0) begin
            win = 2'd0;
        end else if (rr_req) begin
            win = rr_ptr;
        end else begin
            win = rr_other;
        end
        case (win)
            2'd1: begin
                sel_we   = bus.we[1];
                sel_addr = bus.addr1;
                sel_len  = bus.len1;
            end
            2'd2: begin
                sel_we   = bus.we[2];
                sel_addr = bus.addr2;
                sel_len  = bus.len2;
            end
            default: begin
                sel_we   = bus.we[0];
                sel_addr = bus.addr0;
                sel_len  = bus.len0;
            end
        endcase
        len_m1 = sel_len - 7'd1;
    end

    assign owner_done = |(bus.done & gnt);
    assign wd_expire  = (wd_cnt == 10'(TIMEOUT - 1));

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (|bus.req) next_state = CMD;
            CMD:     if (!bus.cmd_full) next_state = DATA;
            DATA:    if (owner_done || wd_expire) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            gnt           <= 3'b000;
            cmd_instr     <= 3'b000;
            cmd_bl        <= 6'd0;
            cmd_byte_addr <= '0;
            err_timeout   <= 1'b0;
            err_count     <= 8'd0;
            rr_ptr        <= 2'd1;
            disp_run      <= '0;
            wd_cnt        <= 10'd0;
        end else begin
            state       <= next_state;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        gnt           <= 3'(3'b001 << win);
                        cmd_instr     <= sel_we ? 3'b000 : 3'b001;
                        cmd_bl        <= len_m1[5:0];
                        cmd_byte_addr <= {sel_addr, 2'b00};
                        if (pick0) begin
                            if (disp_run != DW'(MAX_DISP)) disp_run <= disp_run + DW'(1);
                        end else begin
                            disp_run <= '0;
                            rr_ptr   <= (win == 2'd1) ? 2'd2 : 2'd1;
                        end
                    end
                end
                CMD: wd_cnt <= 10'd0;
                DATA: begin
                    wd_cnt <= wd_cnt + 10'd1;
                    if (owner_done) begin
                        gnt <= 3'b000;
                    end else if (wd_expire) begin
                        gnt         <= 3'b000;
                        err_timeout <= 1'b1;
                        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt           = gnt;
    assign bus.cmd_en        = (state == CMD) && !bus.cmd_full;
    assign bus.cmd_instr     = cmd_instr;
    assign bus.cmd_bl        = cmd_bl;
    assign bus.cmd_byte_addr = cmd_byte_addr;
    assign bus.busy          = (state != IDLE);
    assign bus.err_timeout   = err_timeout;
    assign bus.err_count     = err_count;
    assign bus.state_dbg     = state;
endmodule

// File: tb/tb_ddr_line_arbiter.sv
// Directed bench for ddr_line_arbiter: expected commands are queued by the
// stimulus and checked by a monitor each time cmd_en fires.
module tb_ddr_line_arbiter;
  localparam int ADDR_W  = 28;
  localparam int TIMEOUT = 20;

  localparam logic [41:0] EXP0     = {3'b001, 3'b001, 6'd39, 30'h0000400};
  localparam logic [41:0] EXP1     = {3'b010, 3'b000, 6'd63, 30'h02AF37BC};
  localparam logic [41:0] EXP2     = {3'b100, 3'b001, 6'd0,  30'h3FFFFFFC};
  localparam logic [41:0] EXP0_L0  = {3'b001, 3'b001, 6'd63, 30'h0000400};
  localparam logic [41:0] EXP0_W65 = {3'b001, 3'b000, 6'd0,  30'h0000400};

  logic clk;
  logic reset_n;
  logic auto_done;
  logic [2:0] done_resp;
  logic [2:0] done_drv;
  int checks;
  int failures;
  logic [41:0] exp_q[$];

  ddr_line_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  ddr_line_arbiter #(.ADDR_W(ADDR_W), .MAX_DISP(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  assign bus.done = done_resp | done_drv;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset_n) begin
      check("gnt_onehot0", 64'($onehot0(bus.gnt)), 64'd1);
      if (bus.cmd_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_cmd", 64'd1, 64'd0);
        end else begin
          check("cmd", 64'({bus.gnt, bus.cmd_instr, bus.cmd_bl, bus.cmd_byte_addr}),
                64'(exp_q.pop_front()));
        end
      end
    end
  end

  // requester model: done five cycles after each command, then expect an idle gap
  initial begin
    logic [2:0] g;
    done_resp = 3'b000;
    forever begin
      @(negedge clk);
      if (auto_done && reset_n && bus.cmd_en) begin
        g = bus.gnt;
        repeat (5) @(posedge clk);
        #1 done_resp = g;
        @(posedge clk);
        #1 done_resp = 3'b000;
        @(negedge clk);
        check("idle_gap", 64'({bus.busy, bus.gnt}), 64'd0);
      end
    end
  end

  // driver tasks
  task automatic wait_cmd_en(input string name);
    int n = 0;
    @(negedge clk);
    while (!bus.cmd_en && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(bus.cmd_en), 64'd1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(bus.busy), 64'd0);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_err(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.err_timeout && cyc < 100);
    check("t5_err_pulse", 64'(bus.err_timeout), 64'd1);
  endtask

  initial begin
    int cyc;
    checks = 0;
    failures = 0;
    auto_done = 1'b1;
    done_drv = 3'b000;
    reset_n = 1'b0;
    bus.req = 3'b000;
    bus.we = 3'b010;
    bus.addr0 = 28'h0000100;
    bus.addr1 = 28'h0ABCDEF;
    bus.addr2 = 28'hFFFFFFF;
    bus.len0 = 7'd40;
    bus.len1 = 7'd64;
    bus.len2 = 7'd1;
    bus.cmd_full = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_gnt", 64'(bus.gnt), 64'd0);
    check("rst_cmd_en", 64'(bus.cmd_en), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_err", 64'({bus.err_timeout, bus.err_count}), 64'd0);
    check("rst_cmd", 64'({bus.cmd_instr, bus.cmd_bl, bus.cmd_byte_addr}), 64'd0);

    // single display read
    exp_q.push_back(EXP0);
    @(posedge clk);
    #1 bus.req = 3'b001;
    @(negedge clk);
    check("t1_gnt_idle", 64'(bus.gnt), 64'd0);
    @(negedge clk);
    check("t1_gnt_plus1", 64'(bus.gnt), 64'd1);
    check("t1_cmd_en", 64'(bus.cmd_en), 64'd1);
    @(posedge clk);
    #1 bus.req = 3'b000;
    @(negedge clk);
    check("t1_cmd_en_pulse", 64'({bus.cmd_en, bus.busy}), 64'b01);
    wait_idle("t1_idle");

    // capture/processing round-robin
    exp_q.push_back(EXP1);
    exp_q.push_back(EXP2);
    exp_q.push_back(EXP1);
    exp_q.push_back(EXP2);
    @(posedge clk);
    #1 bus.req = 3'b110;
    wait_drain("t2_drain");
    @(posedge clk);
    #1 bus.req = 3'b000;
    wait_idle("t2_idle");

    // display starvation limit
    for (int i = 0; i < 10; i++) begin
      if (i == 4) exp_q.push_back(EXP1);
      else if (i == 9) exp_q.push_back(EXP2);
      else exp_q.push_back(EXP0);
    end
    @(posedge clk);
    #1 bus.req = 3'b111;
    wait_drain("t3_drain");
    @(posedge clk);
    #1 bus.req = 3'b000;
    wait_idle("t3_idle");

    // command FIFO back-pressure, stray done pulses
    exp_q.push_back(EXP1);
    @(posedge clk);
    #1 begin
      bus.cmd_full = 1'b1;
      bus.req = 3'b010;
    end
    @(negedge clk);
    @(negedge clk);
    check("t4_gnt", 64'(bus.gnt), 64'b010);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1 begin
          bus.req = 3'b000;
          done_drv = (i == 1) ? 3'b010 : 3'b000;
        end
        @(negedge clk);
      end
      check("t4_stall_cmd_en", 64'(bus.cmd_en), 64'd0);
      check("t4_stall_cmd", 64'({bus.gnt, bus.cmd_instr, bus.cmd_bl, bus.cmd_byte_addr}), 64'(EXP1));
    end
    @(posedge clk);
    #1 begin
      bus.cmd_full = 1'b0;
      done_drv = 3'b010;
    end
    @(negedge clk);
    check("t4_cmd_en", 64'(bus.cmd_en), 64'd1);
    @(posedge clk);
    #1 done_drv = 3'b001;
    @(negedge clk);
    check("t4_hold_cmd_done", 64'({bus.busy, bus.gnt}), 64'b1010);
    @(posedge clk);
    #1 done_drv = 3'b000;
    @(negedge clk);
    check("t4_hold_other_done", 64'({bus.busy, bus.gnt, bus.cmd_en}), 64'b10100);
    wait_idle("t4_idle");

    // watchdog aborts with saturation
    auto_done = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      exp_q.push_back((n % 2 == 1) ? EXP2 : EXP1);
      if (n == 1) begin
        @(posedge clk);
        #1 bus.req = 3'b110;
      end
      wait_cmd_en("t5_cmd_seen");
      if (n == 300) begin
        @(posedge clk);
        #1 bus.req = 3'b000;
      end
      wait_err(cyc);
      check("t5_cycles", 64'(cyc), 64'(TIMEOUT + 1));
      check("t5_gnt", 64'(bus.gnt), 64'd0);
      check("t5_err_count", 64'(bus.err_count), 64'((n < 255) ? n : 255));
    end
    @(negedge clk);
    check("t5_err_single", 64'({bus.err_timeout, bus.busy}), 64'd0);
    check("t5_err_sat", 64'(bus.err_count), 64'd255);

    // asynchronous reset mid-DATA
    exp_q.push_back(EXP0);
    @(posedge clk);
    #1 bus.req = 3'b001;
    wait_cmd_en("t6_cmd_seen");
    @(posedge clk);
    #1 bus.req = 3'b000;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("t6_rst_gnt", 64'(bus.gnt), 64'd0);
    check("t6_rst_busy_en", 64'({bus.busy, bus.cmd_en}), 64'd0);
    check("t6_rst_err_count", 64'(bus.err_count), 64'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("t6_post_idle", 64'({bus.state_dbg, bus.busy, bus.gnt}), 64'd0);
    auto_done = 1'b1;
    exp_q.push_back(EXP0_L0);
    @(posedge clk);
    #1 begin
      bus.len0 = 7'd0;
      bus.req = 3'b001;
    end
    wait_drain("t6_len0_drain");
    @(posedge clk);
    #1 bus.req = 3'b000;
    wait_idle("t6_len0_idle");
    exp_q.push_back(EXP0_W65);
    @(posedge clk);
    #1 begin
      bus.len0 = 7'd65;
      bus.we = 3'b011;
      bus.req = 3'b001;
    end
    wait_drain("t6_len65_drain");
    @(posedge clk);
    #1 bus.req = 3'b000;
    wait_idle("t6_len65_idle");

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ddr_line_arbiter.md
Name: ddr_line_arbiter

Overview:
- Shares the single DDR2 MCB command port, on the memory clock, among three burst requesters:
  - req0: display line preload read (deadline-critical).
  - req1: HDMI-in capture write.
  - req2: motion-segmentation processing read/write.
- Requester 0 wins whenever it requests, subject to an anti-starvation limit. Requesters 1 and 2 round-robin.
- Grants are held from command issue until the owning requester reports data-phase completion. A watchdog recovers from a requester that never reports completion.

Parameters:
- ADDR_W, 28, word-address width (32-bit words); byte address = {addr, 2'b00}.
- MAX_DISP, 4, maximum consecutive req0 grants while req1/req2 are pending.
- TIMEOUT, 1023, DATA-state cycles before the watchdog aborts; 1..1023, counter is 10 bits.

Ports:
- clk  in  1  memory-controller clock (100 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- req  in  3  per-requester burst request, level, held until granted.
- we  in  3  per-requester direction: 1 = write, 0 = read.
- addr0/addr1/addr2  in  ADDR_W each  per-requester start word address.
- len0/len1/len2  in  7 each  per-requester burst length in words, 1..64.
- done  in  3  per-requester 1-cycle pulse: data phase finished.
- gnt  out  3  one-hot grant.
- cmd_en  out  1  MCB command strobe.
- cmd_instr  out  3  3'b000 = write, 3'b001 = read.
- cmd_bl  out  6  burst length minus 1.
- cmd_byte_addr  out  ADDR_W+2  byte address.
- cmd_full  in  1  MCB command FIFO full.
- busy  out  1  state != IDLE.
- err_timeout  out  1  1-cycle pulse on watchdog abort.
- err_count  out  8  saturating watchdog-abort count.

Behaviour:
- Reset (async assert, sync release) clears:
  - state = IDLE; gnt, cmd_en, busy, err_timeout = 0; cmd_* = 0; err_count = 0.
  - rr_ptr = 1 (next round-robin candidate); disp_run = 0.
- State IDLE: when any req bit is set, pick a winner combinationally and register it. Next cycle: state = CMD, gnt = winner one-hot, and winner's we/addr/len latched into cmd_instr, cmd_byte_addr, cmd_bl.
- Selection rule:
  - If req[0] and (disp_run < MAX_DISP or req[2:1] == 0): winner = 0, disp_run++ (saturating).
  - Otherwise winner = rr_ptr if req[rr_ptr], else the other of 1/2. disp_run cleared; rr_ptr = the other of 1/2 from the winner.
  - A req0-only stream never stalls.
- State CMD:
  - cmd_full == 0: cmd_en = 1 for exactly that one cycle, then state = DATA.
  - cmd_full == 1: cmd_en = 0; stay in CMD, holding cmd_* stable.
- State DATA:
  - gnt held; watchdog counts from 0.
  - On done[winner]: next cycle state = IDLE, gnt = 0. This is a mandatory one-cycle idle gap; a new arbitration occurs in the IDLE cycle.
  - done bits of non-granted requesters are ignored.
  - Watchdog reaching TIMEOUT: err_timeout pulses 1 cycle, err_count++ (saturating at 255), state = IDLE, gnt = 0.
- Width/arithmetic rules:
  - cmd_bl = len - 1, truncated to 6 bits.
  - len = 0 is illegal; it produces cmd_bl = 6'h3F (64 words).
  - len > 64 is truncated by the same rule.
- Latency: req rising in IDLE gives gnt at +1 cycle and earliest cmd_en at +1 cycle (same cycle as first CMD cycle). Minimum back-to-back grant spacing is 3 cycles + data phase.
- Boundary conditions:
  - done in the same cycle as cmd_en (in CMD) is ignored.
  - Requester dropping req while granted does not release the grant; only done or the watchdog do.
  - Reset mid-burst aborts immediately: gnt = 0, no cmd_en.

Test Plan:
- Reset, req = 3'b001, we0 = 0, addr0 = 28'h0000100, len0 = 40, cmd_full = 0 → gnt = 001 at +1; cmd_en single pulse; cmd_instr = 001, cmd_bl = 39, cmd_byte_addr = 30'h0000400; done[0] → gnt = 0 next cycle.
- req = 3'b110 held, done returned 5 cycles after each cmd_en → grant order 1, 2, 1, 2; gnt never two-hot; one idle cycle between grants.
- req = 3'b111 continuously (MAX_DISP = 4) → grant order 0, 0, 0, 0, 1, 0, 0, 0, 0, 2.
- cmd_full = 1 for 7 cycles after grant → cmd_en stays 0, cmd_* stable; cmd_en pulses once in the cycle cmd_full falls.
- Granted requester never pulses done (TIMEOUT = 20) → err_timeout pulse 20 cycles into DATA; err_count 0 → 1; arbiter then serves a pending req; 300 such aborts → err_count = 255.
- Assert reset_n = 0 asynchronously mid-DATA → gnt, busy, cmd_en = 0 immediately; after release, state IDLE; len0 = 0 → cmd_bl = 63.
